axis_bscan_arbiter: RTL and testbench
=====================================

Name: axis_bscan_arbiter

Overview:
- Shares one 32-bit host-link stream pair (the JTAG boundary-scan bridge) between N on-chip requesters.
- TX path: round-robin grants, prefixes each packet with a header word, then forwards the payload.
- RX path: parses incoming headers and routes each payload to the requester named in the header.
- Sits between the user AXIS endpoints and the bridge's s_axis/m_axis ports, all in the aclk domain.

Parameters:
- N, 4, number of requesters (2..16)
- MAGIC, 4'hA, header tag nibble in bits [31:28]

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous active-high reset
- req_tdata  in  N*32  requester i payload in slice [32i+31:32i]
- req_tvalid  in  N  per-requester valid
- req_tready  out  N  per-requester ready
- req_len  in  N*16  payload word count for the pending packet, stable while req_tvalid is high
- rsp_tdata  out  N*32  routed response payload (shared bus, replicated to every slice)
- rsp_tvalid  out  N  per-requester valid
- rsp_tready  in  N  per-requester ready
- m_axis_tdata  out  32  to bridge s_axis
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- s_axis_tdata  in  32  from bridge m_axis
- s_axis_tvalid  in  1
- s_axis_tready  out  1
- rx_err  out  1  one-cycle pulse per dropped bad header

Behaviour:
- Clock and reset: one clock, aclk; reset is synchronous and active-high (areset).
- Reset values: all outputs 0; TX FSM = T_IDLE; RX FSM = R_HDR; round-robin pointer = 0.
- Header format: {MAGIC[3:0], 4'h0, id[7:0], len[15:0]}.

TX FSM (T_IDLE, T_HDR, T_DATA):
- T_IDLE: search from pointer+1 mod N for the first requester with tvalid high.
  - Register its grant id and req_len as cnt; go to T_HDR on the next cycle.
  - Search is one cycle; no grant if no tvalid.
- T_HDR:
  - m_axis_tvalid=1 with the header word.
  - On m_axis_tready: if len==0, go to T_IDLE and advance the pointer to grant; else go to T_DATA.
- T_DATA:
  - Output data and valid are muxed from the granted requester; req_tready[grant] = m_axis_tready; all other readies are 0.
  - Each accepted beat decrements cnt; the beat with cnt==1 returns to T_IDLE with the pointer set to grant.
- Requester valid drops mid-packet: m_axis_tvalid follows it low; the grant is held, with no timeout.
- Minimum header-to-header gap: 1 idle cycle.
- Zero-length packets: req_tready is never asserted; the requester must drop tvalid for at least 1 cycle after the header, otherwise it is regranted.

RX FSM (R_HDR, R_DATA, R_DRAIN):
- R_HDR: s_axis_tready=1. On a beat:
  - Bad magic: pulse rx_err and stay in R_HDR.
  - len==0: stay in R_HDR.
  - id>=N: latch len, go to R_DRAIN.
  - Otherwise latch id and len, go to R_DATA.
- R_DATA:
  - rsp_tvalid[id] = s_axis_tvalid; s_axis_tready = rsp_tready[id]; other rsp_tvalid = 0.
  - Decrement on each beat; the last beat returns to R_HDR.
- R_DRAIN: s_axis_tready=1; discard len words, then go to R_HDR.
- The TX and RX FSMs are fully independent; simultaneous activity is allowed.
- areset mid-packet: both FSMs abort to their reset state at once; partial packets are lost, with no flush.
- Counters are 16-bit; len=65535 is legal.
- Latency: combinational pass-through of data beats (no bubbles in T_DATA/R_DATA).
- Header overhead: 1 cycle grant + 1 beat header.

Optional Feature:
- Macro: AXIS_BSCAN_ARB_STATS_EN
- Defined: adds outputs tx_pkt_cnt[31:0], rx_pkt_cnt[31:0] and rx_err_cnt[15:0].
  - Each counts completed TX packets, completed routed RX packets and bad headers respectively.
  - Wrap-around, cleared by areset.
- Undefined: ports and counters are absent; rx_err remains.

Decomposition:
- Package axis_bscan_arb_pkg:
  - TX/RX state enums
  - header field constants: MAGIC position, ID_LSB=16, LEN_WIDTH=16
  - header pack/unpack functions
- Sub-module rr_arbiter: N-bit request vector plus pointer in, one-hot grant plus index out; combinational search.
- TX and RX FSMs live in the top module.

Test Plan:
- Single requester 2, len=3, words 11,22,33:
  - m_axis shows 0xA0020003, 11, 22, 33
  - req_tready[2] high only during the 3 data beats
- Requesters 0 and 1 both valid, len=1, back-to-back: grants alternate 1,0,1,0 (pointer starts at 0); no requester is granted twice while the other waits.
- RX 0xA0010002, 0x55, 0x66 with rsp_tready[1] low for 5 cycles: s_axis_tready low during that time; then 0x55 and 0x66 on port 1; other rsp_tvalid stay 0.
- RX header 0x50000001: rx_err pulses once; the next word is parsed as a header. RX header 0xA0FF0002 (id 255 >= N): the next 2 words are dropped.
- areset asserted during T_DATA beat 2 of 4: next cycle m_axis_tvalid=0, all req_tready=0, state T_IDLE; the next packet starts with a header.
- With AXIS_BSCAN_ARB_STATS_EN: 5 TX packets, 3 RX packets and 2 bad headers give counters 5/3/2.

Source files
------------

// File: rtl/axis_bscan_arb_pkg.sv
// Shared types and header helpers for the boundary-scan stream arbiter.
// Header layout: {magic[3:0], 4'h0, id[7:0], len[15:0]}.
package axis_bscan_arb_pkg;

  typedef enum logic [1:0] {T_IDLE, T_HDR, T_DATA} tx_state_e;
  typedef enum logic [1:0] {R_HDR, R_DATA, R_DRAIN} rx_state_e;

  localparam int MAGIC_LSB = 28;
  localparam int ID_LSB    = 16;
  localparam int LEN_WIDTH = 16;

  function automatic logic [31:0] hdr_pack(
    input logic [3:0]  magic,
    input logic [7:0]  id,
    input logic [15:0] len
  );
    return {magic, 4'h0, id, len};
  endfunction

  function automatic logic [3:0] hdr_magic(input logic [31:0] w);
    return w[MAGIC_LSB +: 4];
  endfunction

  function automatic logic [7:0] hdr_id(input logic [31:0] w);
    return w[ID_LSB +: 8];
  endfunction

  function automatic logic [15:0] hdr_len(input logic [31:0] w);
    return w[LEN_WIDTH-1:0];
  endfunction

endpackage

// File: rtl/axis_bscan_arbiter_rr_arbiter.sv
// Combinational round-robin search starting one past the pointer.
// Outputs a one-hot grant, its index and an any-request flag.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_j;

  // walk from farthest to nearest so the nearest request wins
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int k = N; k >= 1; k--) begin
      w_j = IW'((int'(i_ptr) + k) % N);
      if (i_req[w_j]) begin
        o_gnt      = '0;
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_bscan_arbiter.sv
// N-to-1 TX arbiter with header insertion and header-routed RX demux.
// Define AXIS_BSCAN_ARB_STATS_EN to add packet/error counters.
module axis_bscan_arbiter
  import axis_bscan_arb_pkg::*;
#(
  parameter int         N     = 4,
  parameter logic [3:0] MAGIC = 4'hA
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic [N*32-1:0] req_tdata,
  input  logic [N-1:0]    req_tvalid,
  output logic [N-1:0]    req_tready,
  input  logic [N*16-1:0] req_len,
  output logic [N*32-1:0] rsp_tdata,
  output logic [N-1:0]    rsp_tvalid,
  input  logic [N-1:0]    rsp_tready,
  output logic [31:0]     m_axis_tdata,
  output logic            m_axis_tvalid,
  input  logic            m_axis_tready,
  input  logic [31:0]     s_axis_tdata,
  input  logic            s_axis_tvalid,
  output logic            s_axis_tready,
  output logic            rx_err
`ifdef AXIS_BSCAN_ARB_STATS_EN
  ,
  output logic [31:0]     tx_pkt_cnt,
  output logic [31:0]     rx_pkt_cnt,
  output logic [15:0]     rx_err_cnt
`endif
);

  localparam int IW = $clog2(N);

  tx_state_e     r_tx_st, w_tx_nxt;
  logic [IW-1:0] r_ptr, r_gnt;
  logic [N-1:0]  r_gnt_oh;
  logic [15:0]   r_tcnt;
  logic          w_tx_load, w_tx_beat, w_tx_done;
  logic [N-1:0]  w_arb_gnt;
  logic [IW-1:0] w_arb_idx;
  logic          w_arb_any;

  rx_state_e     r_rx_st, w_rx_nxt;
  logic [IW-1:0] r_rid;
  logic [15:0]   r_rcnt;
  logic          r_rx_err;
  logic          w_rx_hdr, w_rx_beat, w_rx_done, w_rx_bad;
  logic [3:0]    w_hmag;
  logic [7:0]    w_hid;
  logic [15:0]   w_hlen;
  logic [31:0]   w_rsp_word;

  rr_arbiter #(.N(N), .IW(IW)) u_rr (
    .i_req (req_tvalid),
    .i_ptr (r_ptr),
    .o_gnt (w_arb_gnt),
    .o_idx (w_arb_idx),
    .o_any (w_arb_any)
  );

  always_comb begin
    w_tx_nxt      = r_tx_st;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    req_tready    = '0;
    w_tx_load     = 1'b0;
    w_tx_beat     = 1'b0;
    w_tx_done     = 1'b0;
    unique case (r_tx_st)
      T_IDLE: begin
        if (w_arb_any) begin
          w_tx_load = 1'b1;
          w_tx_nxt  = T_HDR;
        end
      end
      T_HDR: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_pack(MAGIC, 8'(r_gnt), r_tcnt);
        if (m_axis_tready) begin
          if (r_tcnt == '0) begin
            w_tx_done = 1'b1;
            w_tx_nxt  = T_IDLE;
          end else begin
            w_tx_nxt = T_DATA;
          end
        end
      end
      T_DATA: begin
        m_axis_tdata  = req_tdata[int'(r_gnt)*32 +: 32];
        m_axis_tvalid = req_tvalid[r_gnt];
        req_tready    = r_gnt_oh & {N{m_axis_tready}};
        if (m_axis_tvalid && m_axis_tready) begin
          w_tx_beat = 1'b1;
          if (r_tcnt == 16'd1) begin
            w_tx_done = 1'b1;
            w_tx_nxt  = T_IDLE;
          end
        end
      end
      default: w_tx_nxt = T_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_tx_st  <= T_IDLE;
      r_ptr    <= '0;
      r_gnt    <= '0;
      r_gnt_oh <= '0;
      r_tcnt   <= '0;
    end else begin
      r_tx_st <= w_tx_nxt;
      if (w_tx_load) begin
        r_gnt    <= w_arb_idx;
        r_gnt_oh <= w_arb_gnt;
        r_tcnt   <= req_len[int'(w_arb_idx)*16 +: 16];
      end
      if (w_tx_beat) r_tcnt <= r_tcnt - 16'd1;
      if (w_tx_done) r_ptr <= r_gnt;
    end
  end

  assign w_hmag     = hdr_magic(s_axis_tdata);
  assign w_hid      = hdr_id(s_axis_tdata);
  assign w_hlen     = hdr_len(s_axis_tdata);
  assign w_rsp_word = (r_rx_st == R_DATA) ? s_axis_tdata : 32'h0;
  assign rsp_tdata  = {N{w_rsp_word}};
  assign rx_err     = r_rx_err;

  always_comb begin
    w_rx_nxt      = r_rx_st;
    s_axis_tready = 1'b0;
    rsp_tvalid    = '0;
    w_rx_hdr      = 1'b0;
    w_rx_beat     = 1'b0;
    w_rx_done     = 1'b0;
    w_rx_bad      = 1'b0;
    unique case (r_rx_st)
      R_HDR: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          if (w_hmag != MAGIC) begin
            w_rx_bad = 1'b1;
          end else if (w_hlen != '0) begin
            w_rx_hdr = 1'b1;
            w_rx_nxt = (32'(w_hid) >= N) ? R_DRAIN : R_DATA;
          end
        end
      end
      R_DATA: begin
        rsp_tvalid[r_rid] = s_axis_tvalid;
        s_axis_tready     = rsp_tready[r_rid];
        if (s_axis_tvalid && rsp_tready[r_rid]) begin
          w_rx_beat = 1'b1;
          if (r_rcnt == 16'd1) begin
            w_rx_done = 1'b1;
            w_rx_nxt  = R_HDR;
          end
        end
      end
      R_DRAIN: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          w_rx_beat = 1'b1;
          if (r_rcnt == 16'd1) w_rx_nxt = R_HDR;
        end
      end
      default: w_rx_nxt = R_HDR;
    endcase
    // outputs read as zero while reset is held
    if (areset) s_axis_tready = 1'b0;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_rx_st  <= R_HDR;
      r_rid    <= '0;
      r_rcnt   <= '0;
      r_rx_err <= 1'b0;
    end else begin
      r_rx_st  <= w_rx_nxt;
      r_rx_err <= w_rx_bad;
      if (w_rx_hdr) begin
        r_rid  <= w_hid[IW-1:0];
        r_rcnt <= w_hlen;
      end
      if (w_rx_beat) r_rcnt <= r_rcnt - 16'd1;
    end
  end

`ifdef AXIS_BSCAN_ARB_STATS_EN
  logic [31:0] r_tx_pkt, r_rx_pkt;
  logic [15:0] r_err_cnt;

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_tx_pkt  <= '0;
      r_rx_pkt  <= '0;
      r_err_cnt <= '0;
    end else begin
      if (w_tx_done) r_tx_pkt <= r_tx_pkt + 32'd1;
      if (w_rx_done) r_rx_pkt <= r_rx_pkt + 32'd1;
      if (w_rx_bad)  r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  assign tx_pkt_cnt = r_tx_pkt;
  assign rx_pkt_cnt = r_rx_pkt;
  assign rx_err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_axis_bscan_arbiter.sv
// Randomized bench for axis_bscan_arbiter against a queue-based model.
// Build with AXIS_BSCAN_ARB_STATS_EN to also check the counters.
module tb_axis_bscan_arbiter;

  localparam int N = 4;

  logic            aclk = 1'b0;
  logic            areset;
  logic [N*32-1:0] req_tdata;
  logic [N-1:0]    req_tvalid;
  logic [N-1:0]    req_tready;
  logic [N*16-1:0] req_len;
  logic [N*32-1:0] rsp_tdata;
  logic [N-1:0]    rsp_tvalid;
  logic [N-1:0]    rsp_tready;
  logic [31:0]     m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [31:0]     s_axis_tdata;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic            rx_err;
`ifdef AXIS_BSCAN_ARB_STATS_EN
  logic [31:0]     tx_pkt_cnt;
  logic [31:0]     rx_pkt_cnt;
  logic [15:0]     rx_err_cnt;
`endif

  always #5 aclk = ~aclk;

  axis_bscan_arbiter #(.N(N), .MAGIC(4'hA)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .req_tdata     (req_tdata),
    .req_tvalid    (req_tvalid),
    .req_tready    (req_tready),
    .req_len       (req_len),
    .rsp_tdata     (rsp_tdata),
    .rsp_tvalid    (rsp_tvalid),
    .rsp_tready    (rsp_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .rx_err        (rx_err)
`ifdef AXIS_BSCAN_ARB_STATS_EN
    ,
    .tx_pkt_cnt    (tx_pkt_cnt),
    .rx_pkt_cnt    (rx_pkt_cnt),
    .rx_err_cnt    (rx_err_cnt)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  logic [15:0] lenq[N][$];
  logic [31:0] wq[N][$];
  int          widx[N];
  logic [31:0] exp_m[$];
  int          mptr;
  logic [31:0] sx[$];
  logic [31:0] exp_r[N][$];
  int          exp_err, seen_err, exp_rxp, tx_done, rdy2_cyc;
  bit          drop_en, mrand, srand, hold1, in_rst;

  function automatic logic [31:0] hdr(input logic [3:0] mg,
                                      input logic [7:0] id,
                                      input logic [15:0] ln);
    return {mg, 4'h0, id, ln};
  endfunction

  function automatic bit all_empty();
    bit e;
    e = (exp_m.size() == 0) && (sx.size() == 0);
    for (int i = 0; i < N; i++)
      if (lenq[i].size() != 0 || exp_r[i].size() != 0) e = 0;
    return e;
  endfunction

  task automatic add_pkt(input int r, input int len);
    lenq[r].push_back(16'(len));
    for (int k = 0; k < len; k++) wq[r].push_back($urandom);
  endtask

  // plain round-robin over requesters that still hold packets
  task automatic tx_model();
    logic [15:0] lq[N][$];
    logic [31:0] dq[N][$];
    bit          more;
    int          j;
    for (int i = 0; i < N; i++) begin
      lq[i] = lenq[i];
      dq[i] = wq[i];
    end
    more = 1;
    while (more) begin
      more = 0;
      for (int k = 1; k <= N; k++) begin
        j = (mptr + k) % N;
        if (!more && lq[j].size() != 0) begin
          exp_m.push_back(hdr(4'hA, 8'(j), lq[j][0]));
          for (int w = 0; w < int'(lq[j][0]); w++)
            exp_m.push_back(dq[j].pop_front());
          void'(lq[j].pop_front());
          mptr = j;
          more = 1;
        end
      end
    end
  endtask

  task automatic rx_good(input int id, input int len);
    logic [31:0] w;
    sx.push_back(hdr(4'hA, 8'(id), 16'(len)));
    for (int k = 0; k < len; k++) begin
      w = $urandom;
      sx.push_back(w);
      exp_r[id].push_back(w);
    end
    exp_rxp++;
  endtask

  task automatic rx_random(input int cnt);
    int t, ln;
    for (int n = 0; n < cnt; n++) begin
      t = $urandom_range(0, 9);
      if (t <= 5) begin
        rx_good($urandom_range(0, N-1), $urandom_range(1, 4));
      end else if (t == 6) begin
        sx.push_back({4'h5, 12'h000, 16'($urandom)});
        exp_err++;
      end else if (t == 7) begin
        ln = $urandom_range(1, 3);
        sx.push_back(hdr(4'hA, 8'($urandom_range(N, 255)), 16'(ln)));
        for (int k = 0; k < ln; k++) sx.push_back($urandom);
      end else begin
        sx.push_back(hdr(4'hA, 8'($urandom_range(0, N-1)), 16'h0));
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_tvalid[i] = 1'b0;
      req_tdata[i*32 +: 32] = '0;
      if (lenq[i].size() != 0) begin
        req_len[i*16 +: 16] = lenq[i][0];
        req_tdata[i*32 +: 32] = wq[i][0];
        req_tvalid[i] = !(drop_en && widx[i] > 0 &&
                          $urandom_range(0, 3) == 0);
      end
      if (hold1 && i == 1) rsp_tready[i] = 1'b0;
      else rsp_tready[i] = mrand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    m_axis_tready = mrand ? ($urandom_range(0, 3) != 0) : 1'b1;
    s_axis_tvalid = (sx.size() != 0) &&
                    (srand ? ($urandom_range(0, 4) != 0) : 1'b1);
    s_axis_tdata  = (sx.size() != 0) ? sx[0] : 32'h0;
  endtask

  task automatic sample();
    if (in_rst) return;
    if (m_axis_tvalid && m_axis_tready) begin
      if (exp_m.size() == 0) chk("m_extra", 32'd1, 32'd0);
      else chk("m_word", m_axis_tdata, exp_m.pop_front());
    end
    if (req_tready != '0) chk("rdy_onehot", 32'($onehot(req_tready)), 32'd1);
    if (req_tready[2]) rdy2_cyc++;
    for (int i = 0; i < N; i++) begin
      if (req_tvalid[i] && req_tready[i]) begin
        void'(wq[i].pop_front());
        widx[i]++;
        if (widx[i] == int'(lenq[i][0])) begin
          void'(lenq[i].pop_front());
          widx[i] = 0;
          tx_done++;
        end
      end
      if (rsp_tvalid[i] && rsp_tready[i]) begin
        if (exp_r[i].size() == 0) chk("rsp_extra", 32'(i), 32'd99);
        else chk($sformatf("rsp%0d", i), rsp_tdata[i*32 +: 32],
                 exp_r[i].pop_front());
      end
    end
    if (rsp_tvalid != '0) chk("rsp_onehot", 32'($onehot(rsp_tvalid)), 32'd1);
    if (s_axis_tvalid && s_axis_tready) void'(sx.pop_front());
    if (rx_err) seen_err++;
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
    drive();
    @(negedge aclk);
    sample();
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while (k < budget && !all_empty()) begin
      step();
      k++;
    end
    chk(tag, 32'(all_empty()), 32'd1);
    repeat (4) step();
  endtask

  initial begin
    int k;
    areset = 1'b1;
    req_tdata = '0; req_tvalid = '0; req_len = '0; rsp_tready = '0;
    m_axis_tready = 1'b0; s_axis_tdata = '0; s_axis_tvalid = 1'b0;
    mptr = 0; exp_err = 0; seen_err = 0; exp_rxp = 0; tx_done = 0;
    rdy2_cyc = 0; drop_en = 0; mrand = 0; srand = 0; hold1 = 0; in_rst = 0;
    for (int i = 0; i < N; i++) widx[i] = 0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    chk("rst_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_mdata", m_axis_tdata, 32'd0);
    chk("rst_reqrdy", 32'(req_tready), 32'd0);
    chk("rst_rspvld", 32'(rsp_tvalid), 32'd0);
    chk("rst_rspdata", 32'(rsp_tdata != '0), 32'd0);
    chk("rst_srdy", 32'(s_axis_tready), 32'd0);
    chk("rst_rxerr", 32'(rx_err), 32'd0);
    @(posedge aclk); #1; areset = 1'b0;
    @(negedge aclk);
    chk("idle_srdy", 32'(s_axis_tready), 32'd1);

    // two contenders, pointer at 0: grants alternate 1,0,1,0
    for (int n = 0; n < 4; n++) begin
      add_pkt(0, 1);
      add_pkt(1, 1);
    end
    tx_model();
    chk("alt_first_hdr", exp_m[0], 32'hA001_0001);
    drain("alt_drain", 200);

    // single requester 2, three fixed words
    lenq[2].push_back(16'd3);
    wq[2].push_back(32'd11); wq[2].push_back(32'd22); wq[2].push_back(32'd33);
    exp_m.push_back(32'hA002_0003);
    exp_m.push_back(32'd11); exp_m.push_back(32'd22); exp_m.push_back(32'd33);
    mptr = 2;
    rdy2_cyc = 0;
    drain("one_drain", 100);
    chk("rdy2_cycles", 32'(rdy2_cyc), 32'd3);

    // RX back-pressure on port 1 for five cycles
    sx.push_back(32'hA001_0002);
    sx.push_back(32'h55); sx.push_back(32'h66);
    exp_r[1].push_back(32'h55); exp_r[1].push_back(32'h66);
    exp_rxp++;
    hold1 = 1;
    k = 0;
    while (k < 20 && sx.size() != 2) begin step(); k++; end
    chk("hold_hdr_taken", 32'(sx.size()), 32'd2);
    for (int n = 0; n < 5; n++) begin
      step();
      chk("hold_srdy", 32'(s_axis_tready), 32'd0);
      chk("hold_rspvld", 32'(rsp_tvalid), 32'h2);
    end
    hold1 = 0;
    drain("hold_drain", 50);

    // concurrent randomized traffic on both paths
    mrand = 1; drop_en = 1; srand = 1;
    for (int r = 0; r < N; r++)
      for (int p = $urandom_range(1, 3); p > 0; p--)
        add_pkt(r, $urandom_range(1, 6));
    tx_model();
    rx_random(14);
    drain("rand_drain", 4000);
    chk("rand_rxerr", 32'(seen_err), 32'(exp_err));
`ifdef AXIS_BSCAN_ARB_STATS_EN
    chk("st_tx", tx_pkt_cnt, 32'(tx_done));
    chk("st_rx", rx_pkt_cnt, 32'(exp_rxp));
    chk("st_err", 32'(rx_err_cnt), 32'(exp_err));
`endif

    // reset during the second data beat of a 4-word packet
    mrand = 0; drop_en = 0; srand = 0;
    add_pkt(0, 4);
    tx_model();
    k = 0;
    while (k < 20 && widx[0] != 2) begin step(); k++; end
    chk("rst_mid_reach", 32'(widx[0]), 32'd2);
    @(posedge aclk); #1;
    areset = 1'b1; in_rst = 1;
    for (int i = 0; i < N; i++) begin
      lenq[i].delete(); wq[i].delete(); exp_r[i].delete(); widx[i] = 0;
    end
    exp_m.delete(); sx.delete();
    mptr = 0; tx_done = 0; exp_rxp = 0; exp_err = 0; seen_err = 0;
    drive();
    @(posedge aclk); #1;
    areset = 1'b0;
    drive();
    @(negedge aclk);
    in_rst = 0;
    chk("abort_mvalid", 32'(m_axis_tvalid), 32'd0);
    chk("abort_reqrdy", 32'(req_tready), 32'd0);
    add_pkt(3, 2);
    tx_model();
    chk("abort_next_hdr", exp_m[0], 32'hA003_0002);
    drain("abort_drain", 100);

    // bad magic, out-of-range id and zero-length headers
    sx.push_back(32'h5000_0001); exp_err++;
    rx_good(1, 1);
    sx.push_back(32'hA0FF_0002); sx.push_back(32'h1); sx.push_back(32'h2);
    sx.push_back(32'hA000_0000);
    rx_good(3, 1);
    drain("bad_drain", 100);
    chk("bad_rxerr", 32'(seen_err), 32'd1);
`ifdef AXIS_BSCAN_ARB_STATS_EN
    chk("st2_tx", tx_pkt_cnt, 32'(tx_done));
    chk("st2_rx", rx_pkt_cnt, 32'(exp_rxp));
    chk("st2_err", 32'(rx_err_cnt), 32'(exp_err));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
